// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic phase sequencer.
package tl_pkg;

  // State codes double as the external phase output.
  typedef enum logic [3:0] {
    MainG  = 4'd0,
    M2Y    = 4'd1,
    ThruG  = 4'd2,
    MainY  = 4'd3,
    AllRed = 4'd4,
    SideG  = 4'd5,
    SideY  = 4'd6,
    Flash  = 4'd7
  } tl_state_e;

  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] DARK   = 3'b000;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
  } tl_lamps_t;

  // Lamp decode for one state; flash_lit selects the lit or dark half of FLASH.
  function automatic tl_lamps_t lamps_for(tl_state_e st, logic flash_lit);
    tl_lamps_t l;
    l = '{m1: DARK, m2: DARK, mt: DARK, s: DARK};
    case (st)
      MainG:  l = '{m1: GREEN,  m2: GREEN,  mt: RED,    s: RED};
      M2Y:    l = '{m1: GREEN,  m2: YELLOW, mt: RED,    s: RED};
      ThruG:  l = '{m1: GREEN,  m2: RED,    mt: GREEN,  s: RED};
      MainY:  l = '{m1: YELLOW, m2: RED,    mt: YELLOW, s: RED};
      AllRed: l = '{m1: RED,    m2: RED,    mt: RED,    s: RED};
      SideG:  l = '{m1: RED,    m2: RED,    mt: RED,    s: GREEN};
      SideY:  l = '{m1: RED,    m2: RED,    mt: RED,    s: YELLOW};
      Flash: begin
        if (flash_lit) l = '{m1: YELLOW, m2: YELLOW, mt: YELLOW, s: RED};
        else           l = '{m1: DARK,   m2: DARK,   mt: DARK,   s: DARK};
      end
      default: l = '{m1: DARK, m2: DARK, mt: DARK, s: DARK};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clock cycles.
module tl_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] Last = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Tick on the terminal count; with TICK_DIV=1 the count is stuck at 0 and tick is constant.
  assign tick = (cnt_q == Last);

  // Wrap explicitly at TICK_DIV-1 so non-power-of-two dividers never overrun.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (tick) cnt_d = '0;
  end

  // Prescaler count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Traffic phase sequencer: main/through/side phases with demand latch and flash mode.
module traffic_phase_sequencer
  import tl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_MAIN   = 7,
  parameter int unsigned T_M2Y    = 2,
  parameter int unsigned T_THRU   = 5,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_SIDE   = 3,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_FLASH  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       flash_en,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [3:0] phase,
  output logic       side_pending
);

  tl_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             side_pending_q, side_pending_d;
  logic             after_side_q, after_side_d;
  logic             flash_lit_q, flash_lit_d;
  logic             tick;
  logic             cnt_last;
  logic             state_legal;
  tl_lamps_t        lamps;

  tl_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Terminal count (duration minus one) of the phase counter for each state.
  function automatic logic [CNT_W-1:0] last_count(tl_state_e st);
    logic [CNT_W-1:0] v;
    v = '0;
    case (st)
      MainG:        v = CNT_W'(T_MAIN - 1);
      M2Y:          v = CNT_W'(T_M2Y - 1);
      ThruG:        v = CNT_W'(T_THRU - 1);
      MainY, SideY: v = CNT_W'(T_YEL - 1);
      AllRed:       v = CNT_W'(T_ALLRED - 1);
      SideG:        v = CNT_W'(T_SIDE - 1);
      Flash:        v = CNT_W'(T_FLASH - 1);
      default:      v = '0;
    endcase
    return v;
  endfunction

  assign cnt_last = (cnt_q == last_count(state_q));

  // Next-state, counter, flash-half, after_side and demand-latch logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    after_side_d   = after_side_q;
    flash_lit_d    = flash_lit_q;
    side_pending_d = side_pending_q | side_req;
    state_legal    = (state_q <= Flash);

    if (flash_en) begin
      state_d = Flash;
      if (state_q != Flash) begin
        // Always enter flash in the lit half with a fresh count.
        cnt_d       = '0;
        flash_lit_d = 1'b1;
      end else if (tick) begin
        if (cnt_last) begin
          cnt_d       = '0;
          flash_lit_d = ~flash_lit_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (state_q == Flash) begin
      // Leave flash through a clearance interval that always returns to main green.
      state_d      = AllRed;
      after_side_d = 1'b1;
      cnt_d        = '0;
      flash_lit_d  = 1'b1;
    end else if (!state_legal) begin
      state_d      = MainG;
      after_side_d = 1'b0;
      cnt_d        = '0;
    end else if (tick) begin
      if (cnt_last) begin
        cnt_d = '0;
        case (state_q)
          MainG: state_d = M2Y;
          M2Y:   state_d = ThruG;
          ThruG: state_d = MainY;
          MainY: state_d = AllRed;
          AllRed: begin
            if (after_side_q) begin
              state_d      = MainG;
              after_side_d = 1'b0;
            end else if (side_pending_q) begin
              state_d = SideG;
            end else begin
              state_d = MainG;
            end
          end
          SideG: state_d = SideY;
          SideY: begin
            state_d      = AllRed;
            after_side_d = 1'b1;
          end
          default: state_d = MainG;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Serving the side road consumes the demand; this beats a same-cycle request.
    if (state_d == SideG && state_q != SideG) side_pending_d = 1'b0;
  end

  // State and bookkeeping registers; reset overrides flash_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= MainG;
      cnt_q          <= '0;
      side_pending_q <= 1'b0;
      after_side_q   <= 1'b0;
      flash_lit_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      side_pending_q <= side_pending_d;
      after_side_q   <= after_side_d;
      flash_lit_q    <= flash_lit_d;
    end
  end

  // Lamps are a pure decode of the registered state.
  always_comb begin
    lamps = lamps_for(state_q, flash_lit_q);
  end

  assign light_M1     = lamps.m1;
  assign light_M2     = lamps.m2;
  assign light_MT     = lamps.mt;
  assign light_S      = lamps.s;
  assign phase        = state_q;
  assign side_pending = side_pending_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer (default timing plus a TICK_DIV=4 instance).
module tb_traffic_phase_sequencer;

  logic       clk;
  logic       rst;
  logic       side_req;
  logic       flash_en;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic [3:0] phase;
  logic       side_pending;
  logic [2:0] light_M1_4, light_M2_4, light_MT_4, light_S_4;
  logic [3:0] phase_4;
  logic       side_pending_4;

  int total;
  int bad;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] D = 3'b000;

  traffic_phase_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .side_req    (side_req),
    .flash_en    (flash_en),
    .light_M1    (light_M1),
    .light_M2    (light_M2),
    .light_MT    (light_MT),
    .light_S     (light_S),
    .phase       (phase),
    .side_pending(side_pending)
  );

  traffic_phase_sequencer #(
    .TICK_DIV(4)
  ) dut4 (
    .clk         (clk),
    .rst         (rst),
    .side_req    (side_req),
    .flash_en    (flash_en),
    .light_M1    (light_M1_4),
    .light_M2    (light_M2_4),
    .light_MT    (light_MT_4),
    .light_S     (light_S_4),
    .phase       (phase_4),
    .side_pending(side_pending_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected phase code at cycle c of a round that serves the side road.
  function automatic logic [3:0] side_round_phase(int c);
    if (c < 7)  return 4'd0;
    if (c < 9)  return 4'd1;
    if (c < 14) return 4'd2;
    if (c < 16) return 4'd3;
    if (c < 17) return 4'd4;
    if (c < 20) return 4'd5;
    if (c < 22) return 4'd6;
    return 4'd4;
  endfunction

  // Expected phase code at cycle c of a round without side demand.
  function automatic logic [3:0] main_round_phase(int c);
    if (c < 7)  return 4'd0;
    if (c < 9)  return 4'd1;
    if (c < 14) return 4'd2;
    if (c < 16) return 4'd3;
    if (c < 17) return 4'd4;
    return 4'd0;
  endfunction

  // Expected {M1,M2,MT,S} lamps for a non-flash phase code.
  function automatic logic [11:0] exp_lamps(logic [3:0] p);
    case (p)
      4'd0:    return {G, G, R, R};
      4'd1:    return {G, Y, R, R};
      4'd2:    return {G, R, G, R};
      4'd3:    return {Y, R, Y, R};
      4'd4:    return {R, R, R, R};
      4'd5:    return {R, R, R, G};
      4'd6:    return {R, R, R, Y};
      default: return {D, D, D, D};
    endcase
  endfunction

  // Reset both instances; returns at the sampling point of cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    side_req = 1'b0;
    flash_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] l;
    do_reset();
    l = {light_M1, light_M2, light_MT, light_S};
    total++;
    if (phase !== 4'd0) begin
      bad++;
      $display("FAIL reset_phase: got %0d want 0", phase);
    end
    total++;
    if (l !== {G, G, R, R}) begin
      bad++;
      $display("FAIL reset_lamps: got %h want %h", l, {G, G, R, R});
    end
    total++;
    if (side_pending !== 1'b0) begin
      bad++;
      $display("FAIL reset_side_pending: got %b want 0", side_pending);
    end
    total++;
    if (phase_4 !== 4'd0) begin
      bad++;
      $display("FAIL reset_phase_div4: got %0d want 0", phase_4);
    end
  endtask

  task automatic test_normal_cycle();
    logic [3:0]  ep;
    logic [11:0] l;
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      ep = main_round_phase(c);
      l  = {light_M1, light_M2, light_MT, light_S};
      total++;
      if (phase !== ep) begin
        bad++;
        $display("FAIL normal_phase c=%0d: got %0d want %0d", c, phase, ep);
      end
      total++;
      if (l !== exp_lamps(ep)) begin
        bad++;
        $display("FAIL normal_lamps c=%0d: got %h want %h", c, l, exp_lamps(ep));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tick_div4();
    logic [3:0] ep;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      ep = (c < 28) ? 4'd0 : (c < 36) ? 4'd1 : 4'd2;
      total++;
      if (phase_4 !== ep) begin
        bad++;
        $display("FAIL div4_phase c=%0d: got %0d want %0d", c, phase_4, ep);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_side_pulse();
    logic [3:0]  ep;
    logic        es;
    logic [11:0] l;
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      ep = (c == 23 || c == 24) ? 4'd0 : side_round_phase(c);
      es = (c >= 4 && c <= 16);
      l  = {light_M1, light_M2, light_MT, light_S};
      total++;
      if (phase !== ep) begin
        bad++;
        $display("FAIL side_pulse_phase c=%0d: got %0d want %0d", c, phase, ep);
      end
      total++;
      if (side_pending !== es) begin
        bad++;
        $display("FAIL side_pulse_pending c=%0d: got %b want %b", c, side_pending, es);
      end
      total++;
      if (l !== exp_lamps(ep)) begin
        bad++;
        $display("FAIL side_pulse_lamps c=%0d: got %h want %h", c, l, exp_lamps(ep));
      end
      side_req = (c == 3);
      @(negedge clk);
    end
    side_req = 1'b0;
  endtask

  task automatic test_flash();
    logic [3:0]  ep;
    logic [11:0] el;
    logic [11:0] l;
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      if (c <= 10) begin
        ep = main_round_phase(c);
        el = exp_lamps(ep);
      end else if (c <= 15) begin
        ep = 4'd7;
        el = (c % 2 == 1) ? {Y, Y, Y, R} : {D, D, D, D};
      end else if (c == 16) begin
        ep = 4'd4;
        el = exp_lamps(ep);
      end else begin
        ep = 4'd0;
        el = exp_lamps(ep);
      end
      l = {light_M1, light_M2, light_MT, light_S};
      total++;
      if (phase !== ep) begin
        bad++;
        $display("FAIL flash_phase c=%0d: got %0d want %0d", c, phase, ep);
      end
      total++;
      if (l !== el) begin
        bad++;
        $display("FAIL flash_lamps c=%0d: got %h want %h", c, l, el);
      end
      if (c == 13 || c == 17) begin
        total++;
        if (side_pending !== 1'b1) begin
          bad++;
          $display("FAIL flash_side_latch c=%0d: got %b want 1", c, side_pending);
        end
      end
      flash_en = (c >= 10 && c <= 14);
      side_req = (c == 12);
      @(negedge clk);
    end
    flash_en = 1'b0;
    side_req = 1'b0;
  endtask

  task automatic test_reset_in_side();
    do_reset();
    side_req = 1'b1;
    for (int c = 0; c < 18; c++) @(negedge clk);
    // Cycle 18: second SIDE_G cycle with demand re-latched.
    total++;
    if (phase !== 4'd5 || side_pending !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_side: got phase=%0d pend=%b want phase=5 pend=1",
               phase, side_pending);
    end
    rst      = 1'b1;
    flash_en = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    flash_en = 1'b0;
    side_req = 1'b0;
    total++;
    if (phase !== 4'd0 || side_pending !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_side: got phase=%0d pend=%b want phase=0 pend=0",
               phase, side_pending);
    end
    // Counter restarted from 0: MAIN_G lasts a full 7 cycles.
    for (int c = 0; c < 8; c++) begin
      total++;
      if (phase !== ((c < 7) ? 4'd0 : 4'd1)) begin
        bad++;
        $display("FAIL reset_in_side_count c=%0d: got %0d want %0d", c, phase,
                 (c < 7) ? 0 : 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_side_held();
    logic [3:0] ep;
    logic       es;
    int         rc;
    do_reset();
    side_req = 1'b1;
    for (int c = 0; c < 47; c++) begin
      rc = c % 23;
      ep = side_round_phase(rc);
      es = !(c == 0 || rc == 17);
      total++;
      if (phase !== ep) begin
        bad++;
        $display("FAIL held_phase c=%0d: got %0d want %0d", c, phase, ep);
      end
      total++;
      if (side_pending !== es) begin
        bad++;
        $display("FAIL held_pending c=%0d: got %b want %b", c, side_pending, es);
      end
      @(negedge clk);
    end
    side_req = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    side_req = 1'b0;
    flash_en = 1'b0;
    test_reset();
    test_normal_cycle();
    test_tick_div4();
    test_side_pulse();
    test_flash();
    test_reset_in_side();
    test_side_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
